// File: rtl/sprite_pkg.sv
// Constants and FSM encoding shared by the sprite loader, the sprite memory and the RGB
// output path.
package sprite_pkg;

    localparam int DATA_BITS    = 12;
    localparam int ADDR_BITS    = 10;
    localparam int ELEMENT_BITS = 3;
    localparam int SPRITE_WORDS = 400;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } loader_state_e;

endpackage : sprite_pkg

// File: rtl/sprite_loader_if.sv
// Pixel stream handshake plus sprite-memory write port.
// The loader sits on the slave side; the host and the memory sit on the master side.
interface sprite_loader_if #(
    parameter int ELEMENT_BITS = sprite_pkg::ELEMENT_BITS,
    parameter int ADDR_BITS    = sprite_pkg::ADDR_BITS,
    parameter int DATA_BITS    = sprite_pkg::DATA_BITS
);
    logic                    in_valid;
    logic [DATA_BITS-1:0]    in_data;
    logic                    in_ready;
    logic                    write_enable;
    logic [ELEMENT_BITS-1:0] write_element;
    logic [ADDR_BITS-1:0]    write_address;
    logic [DATA_BITS-1:0]    write_data;

    modport slave (
        input  in_valid, in_data,
        output in_ready, write_enable, write_element, write_address, write_data
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, write_enable, write_element, write_address, write_data
    );
endinterface : sprite_loader_if

// File: rtl/sprite_addr_counter.sv
// Word address counter for one sprite load.
// Clear has priority over increment, and last_o flags the final word of the sprite.
module sprite_addr_counter #(
    parameter int ADDR_BITS    = sprite_pkg::ADDR_BITS,
    parameter int SPRITE_WORDS = sprite_pkg::SPRITE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 inc_i,
    output logic [ADDR_BITS-1:0] count_o,
    output logic                 last_o
);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(SPRITE_WORDS - 1);

    logic [ADDR_BITS-1:0] count_q;
    logic [ADDR_BITS-1:0] count_d;

    // next count: clear, step or hold
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + ADDR_BITS'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST_ADDR);

endmodule : sprite_addr_counter

// File: rtl/sprite_loader.sv
// Streams handshaked pixels into one sprite slot of the sprite memory.
// Optionally holds off the stream during active video so displayed sprites never tear.
module sprite_loader
    import sprite_pkg::*;
#(
    parameter int ELEMENT_BITS = sprite_pkg::ELEMENT_BITS,
    parameter int ADDR_BITS    = sprite_pkg::ADDR_BITS,
    parameter int DATA_BITS    = sprite_pkg::DATA_BITS,
    parameter int SPRITE_WORDS = sprite_pkg::SPRITE_WORDS,
    parameter bit BLANK_ONLY   = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [ELEMENT_BITS-1:0] start_element,
    input  logic                    abort,
    input  logic                    video_enable,
    output logic                    busy,
    output logic                    done,
    sprite_loader_if.slave          bus
);
    loader_state_e           state_q;
    logic [ELEMENT_BITS-1:0] element_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    we_q;
    logic [ELEMENT_BITS-1:0] wr_element_q;
    logic [ADDR_BITS-1:0]    wr_address_q;
    logic [DATA_BITS-1:0]    wr_data_q;

    logic [ADDR_BITS-1:0]    count_s;
    logic                    last_s;
    logic                    ready_s;
    logic                    xfer_s;
    logic                    launch_s;

    // handshake decode; abort beats start so an aborted request never launches
    always_comb begin
        ready_s  = (state_q == ST_STREAM) && (!video_enable || !BLANK_ONLY);
        xfer_s   = ready_s && bus.in_valid;
        launch_s = (state_q == ST_IDLE) && start && !abort;
    end

    sprite_addr_counter #(
        .ADDR_BITS    (ADDR_BITS),
        .SPRITE_WORDS (SPRITE_WORDS)
    ) u_addr_counter (
        .clk     (clk),
        .rst_n   (reset),
        .clear_i (launch_s),
        .inc_i   (xfer_s),
        .count_o (count_s),
        .last_o  (last_s)
    );

    // load FSM with registered write port and status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            element_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            we_q         <= 1'b0;
            wr_element_q <= '0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
        end else begin
            // a beat accepted in the abort cycle is still written
            we_q   <= xfer_s;
            done_q <= 1'b0;
            if (xfer_s) begin
                wr_element_q <= element_q;
                wr_address_q <= count_s;
                wr_data_q    <= bus.in_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (launch_s) begin
                        element_q <= start_element;
                        state_q   <= ST_STREAM;
                        busy_q    <= 1'b1;
                    end else begin
                        busy_q    <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (xfer_s && last_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready      = ready_s;
    assign bus.write_enable  = we_q;
    assign bus.write_element = wr_element_q;
    assign bus.write_address = wr_address_q;
    assign bus.write_data    = wr_data_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule : sprite_loader
